// File: rtl/pc_next_unit.sv
// pc_next_unit: holds the fetch PC and picks the next one (sequential, branch or jalr).
// Latency: o_imem_addr is the PC register; o_if_valid/o_pc_if follow an accepted fetch by one cycle.
// Backpressure: i_stall or a low i_imem_ready holds the PC; misaligned targets trap until reset.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_prePCSrc, i_ex_valid        redirect request from EX (bit1 jalr, bit0 taken branch)
//   i_pc_ex, i_imm_ex, i_rs1_ex   operands for the redirect target
//   i_stall, i_imem_ready         decode backpressure, instruction-memory handshake
//   o_imem_req, o_imem_addr       fetch request and address
//   o_if_valid, o_pc_if           IF/ID slot valid and its PC
//   o_flush                       kill IF/ID and ID/EX (combinational)
//   o_misaligned, o_bad_target    sticky misaligned-target trap and the offending address
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_prePCSrc,
  input  logic        i_ex_valid,
  input  logic [31:0] i_pc_ex,
  input  logic [31:0] i_imm_ex,
  input  logic [31:0] i_rs1_ex,
  input  logic        i_stall,
  input  logic        i_imem_ready,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic        o_if_valid,
  output logic [31:0] o_pc_if,
  output logic        o_flush,
  output logic        o_misaligned,
  output logic [31:0] o_bad_target
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_br_sum;
  logic [31:0] w_target;
  logic        w_in_fetch;
  logic        w_redir;
  logic        w_misal;
  logic        w_accept;
  logic        w_take;

  // Both sums wrap modulo 2^32; jalr clears bit 0 of its sum.
  assign w_jalr_sum = i_rs1_ex + i_imm_ex;
  assign w_br_sum   = i_pc_ex + i_imm_ex;
  assign w_target   = i_prePCSrc[1] ? (w_jalr_sum & ~32'h1) : w_br_sum;
  assign w_misal    = |w_target[1:0];

  assign w_in_fetch = (r_state == ST_FETCH);
  // i_ex_valid gates i_prePCSrc first so an undriven select cannot leak through.
  assign w_redir    = w_in_fetch & i_ex_valid & (|i_prePCSrc);
  assign w_accept   = o_imem_req & i_imem_ready;
  // A fetch accepted while a redirect happens belongs to the wrong path.
  assign w_take     = w_accept & ~i_stall & ~w_redir;

  assign o_imem_req  = w_in_fetch;
  assign o_imem_addr = r_pc;
  assign o_flush     = w_redir;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_redir) begin
          if (w_misal) begin
            w_state_nxt = ST_TRAP;
          end else begin
            w_pc_nxt = w_target;
          end
        end else if (w_accept && !i_stall) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_valid <= 1'b0;
      o_pc_if    <= 32'h0;
    end else begin
      o_if_valid <= w_take;
      if (w_take) begin
        o_pc_if <= r_pc;
      end
    end
  end

  // Trap capture happens once; TRAP never re-enters FETCH, so the values stay sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_misaligned <= 1'b0;
      o_bad_target <= 32'h0;
    end else if (w_redir && w_misal) begin
      o_misaligned <= 1'b1;
      o_bad_target <= w_target;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  src;
  logic        ex_valid;
  logic [31:0] pc_ex, imm_ex, rs1_ex;
  logic        stall, ready;
  logic        imem_req, if_valid, flush, misaligned;
  logic [31:0] imem_addr, pc_if, bad_target;

  // second instance for the wrap check
  logic        rst_b;
  logic        req_b, ifv_b, flush_b, mis_b;
  logic [31:0] addr_b, pcif_b, bad_b;

  int n_chk  = 0;
  int n_pass = 0;

  // bench model
  int          m_state;   // 0 idle, 1 fetch, 2 trap
  logic [31:0] m_pc, m_bad;
  logic        m_mis;
  logic [31:0] sb_q[$];

  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_prePCSrc(src), .i_ex_valid(ex_valid),
    .i_pc_ex(pc_ex), .i_imm_ex(imm_ex), .i_rs1_ex(rs1_ex),
    .i_stall(stall), .i_imem_ready(ready),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .o_if_valid(if_valid), .o_pc_if(pc_if), .o_flush(flush),
    .o_misaligned(misaligned), .o_bad_target(bad_target)
  );

  pc_next_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst(rst_b), .i_prePCSrc(2'b00), .i_ex_valid(1'b0),
    .i_pc_ex(32'h0), .i_imm_ex(32'h0), .i_rs1_ex(32'h0),
    .i_stall(1'b0), .i_imem_ready(1'b1),
    .o_imem_req(req_b), .o_imem_addr(addr_b),
    .o_if_valid(ifv_b), .o_pc_if(pcif_b), .o_flush(flush_b),
    .o_misaligned(mis_b), .o_bad_target(bad_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_reset_outputs(input logic [31:0] rpc);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_ifv", {31'b0, if_valid}, 32'h0);
    check("rst_pcif", pc_if, 32'h0);
    check("rst_mis", {31'b0, misaligned}, 32'h0);
    check("rst_bad", bad_target, 32'h0);
    check("rst_addr", imem_addr, rpc);
  endtask

  // Asserts reset away from the edge, checks outputs clear at once, then releases.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check_reset_outputs(32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_pc = 32'h0; m_mis = 1'b0; m_bad = 32'h0;
    sb_q.delete();
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic ev, input logic [1:0] s, input logic [31:0] pe,
                       input logic [31:0] im, input logic [31:0] r1,
                       input logic st, input logic rd);
    logic        e_req, e_redir, e_acc, e_take;
    logic [31:0] tgt, exp_pc;
    ex_valid = ev; src = s; pc_ex = pe; imm_ex = im; rs1_ex = r1; stall = st; ready = rd;
    #1;
    e_req   = (m_state == 1);
    e_redir = e_req && ev && (s != 2'b00);
    tgt     = s[1] ? ((r1 + im) & ~32'h1) : (pe + im);
    check("req", {31'b0, imem_req}, {31'b0, e_req});
    check("addr", imem_addr, m_pc);
    check("flush", {31'b0, flush}, {31'b0, e_redir});
    e_acc  = e_req && rd;
    e_take = e_acc && !st && !e_redir;
    if (e_take) sb_q.push_back(m_pc);
    case (m_state)
      0: m_state = 1;
      1: begin
        if (e_redir) begin
          if (tgt[1:0] != 2'b00) begin
            m_state = 2; m_mis = 1'b1; m_bad = tgt;
          end else begin
            m_pc = tgt;
          end
        end else if (e_acc && !st) begin
          m_pc = m_pc + 32'd4;
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
    check("if_valid", {31'b0, if_valid}, {31'b0, e_take});
    if (if_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'h1, 32'h0);
      end else begin
        exp_pc = sb_q.pop_front();
        check("pc_if", pc_if, exp_pc);
      end
    end
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    check("bad_target", bad_target, m_bad);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    src = 2'b00; ex_valid = 1'b0; pc_ex = 0; imm_ex = 0; rs1_ex = 0; stall = 1'b0; ready = 1'b1;
    m_state = 0; m_pc = 0; m_mis = 0; m_bad = 0;
    #12;
    check_reset_outputs(32'h0);
    do_reset();

    // IDLE cycle then sequential fetch 0,4,8,C
    fetch(5);
    // PC is 0x10: taken branch to 0x08+0x20
    cycle(1'b1, 2'b01, 32'h08, 32'h20, 32'h0, 1'b0, 1'b1);
    fetch(2);
    // jalr and jalr with both select bits
    cycle(1'b1, 2'b10, 32'h0, 32'h4, 32'h101, 1'b0, 1'b1);
    fetch(1);
    cycle(1'b1, 2'b11, 32'h0, 32'h4, 32'h101, 1'b0, 1'b1);
    fetch(1);
    // EX invalid: select ignored even if unknown
    cycle(1'b0, 2'bxx, 32'h0, 32'h40, 32'h40, 1'b0, 1'b1);
    cycle(1'b0, 2'b11, 32'h0, 32'h40, 32'h40, 1'b0, 1'b1);
    // stall with ready, not ready, both, then release
    cycle(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b1);
    cycle(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b1);
    cycle(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    fetch(2);
    // redirect while the request is not accepted; stalled redirect still wins
    cycle(1'b1, 2'b01, 32'h100, 32'h80, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 32'h0, 32'h10, 32'h1000, 1'b1, 1'b1);
    fetch(2);
    // branch target wrapping past 2^32
    cycle(1'b1, 2'b01, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b1);
    fetch(1);

    // randomized traffic with aligned targets
    for (int i = 0; i < 300; i++) begin
      logic        ev;
      logic [1:0]  s;
      ev = ($urandom_range(0, 9) == 0);
      s  = 2'($urandom_range(0, 3));
      cycle(ev, s, $urandom & ~32'h3, $urandom & ~32'h3, ($urandom & ~32'h3) | 32'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    // reset mid-stream, restart at RESET_PC
    do_reset();
    fetch(4);

    // misaligned branch target traps until reset
    cycle(1'b1, 2'b01, 32'h0, 32'h6, 32'h0, 1'b0, 1'b1);
    fetch(3);
    cycle(1'b1, 2'b01, 32'h0, 32'h8, 32'h0, 1'b0, 1'b1);
    // misaligned jalr (bit1 survives the bit0 clear)
    do_reset();
    fetch(2);
    cycle(1'b1, 2'b10, 32'h0, 32'h2, 32'h1, 1'b0, 1'b1);
    fetch(2);
    // reset out of TRAP
    do_reset();
    fetch(3);

    // wrap instance: first address FFFF_FFFC, second 0
    @(posedge clk); #1;
    check("wrap_rst_addr", addr_b, 32'hFFFF_FFFC);
    check("wrap_rst_req", {31'b0, req_b}, 32'h0);
    rst_b = 1'b0;
    #1;
    check("wrap_idle_req", {31'b0, req_b}, 32'h0);
    @(posedge clk); #1;
    check("wrap_req", {31'b0, req_b}, 32'h1);
    check("wrap_addr0", addr_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_addr1", addr_b, 32'h0);
    check("wrap_ifv", {31'b0, ifv_b}, 32'h1);
    check("wrap_pcif", pcif_b, 32'hFFFF_FFFC);
    check("wrap_flags", {30'b0, flush_b, mis_b}, 32'h0);
    check("wrap_bad", bad_b, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
